csi2tx_multi_sync_filter: RTL and testbench

Parametrised multi-channel synchroniser for asynchronous single-bit control/status signals entering the clk domain. Each channel has a configurable-depth flop chain and an optional stability (glitch) filter. Each channel also has a per-channel output mode: level, rising-edge pulse, or toggle-to-pulse. A sticky, write-1-to-clear event status register feeds the CSI2 TX register/interrupt logic.

---
 rtl/csi2tx_multi_sync_filter_pkg.sv | 19 +
 rtl/csi2tx_sync_chan.sv | 89 ++++++++
 rtl/csi2tx_multi_sync_filter.sv | 52 +++++
 tb/tb_csi2tx_multi_sync_filter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/csi2tx_multi_sync_filter_pkg.sv
// rtl/csi2tx_multi_sync_filter_pkg.sv - shared limits and helpers for the csi2tx sync filter
package csi2tx_multi_sync_filter_pkg;

  localparam int unsigned CSI2TX_SYNC_MIN_STAGES = 2;
  localparam int unsigned CSI2TX_SYNC_MAX_STAGES = 4;
  localparam int unsigned CSI2TX_SYNC_MAX_FILT   = 255;
  localparam int unsigned CSI2TX_SYNC_MAX_CH     = 32;

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csi2tx_sync_chan.sv
// rtl/csi2tx_sync_chan.sv - one channel: sync chain, stability filter, edge detect, sticky status
module csi2tx_sync_chan
  import csi2tx_multi_sync_filter_pkg::*;
#(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned FILTER_CNT = 0,
  parameter logic        RST_VAL    = 1'b0,
  parameter logic        RISE       = 1'b0,
  parameter logic        TGL        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  input  logic evt_clr_i,
  output logic sync_lvl_o,
  output logic sync_pulse_o,
  output logic evt_sts_o
);

  logic [STAGES-1:0] chain_q;
  logic              raw;
  logic              filt;
  logic              filt_dly_q;
  logic              evt_sts_q;
  logic              evt_sts_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= {STAGES{RST_VAL}};
    else        chain_q <= {chain_q[STAGES-2:0], async_i};
  end

  assign raw = chain_q[STAGES-1];

  if (FILTER_CNT == 0) begin : g_nofilt
    assign filt = raw;
  end else begin : g_filt
    localparam int unsigned     CW       = clog2(FILTER_CNT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // Count consecutive cycles raw disagrees with the filtered level; any agreement restarts it.
    always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (raw == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_d = raw;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        filt_q <= RST_VAL;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign filt = filt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) filt_dly_q <= RST_VAL;
    else        filt_dly_q <= filt;
  end

  assign sync_lvl_o   = filt;
  assign sync_pulse_o = TGL  ? (filt ^ filt_dly_q) :
                        RISE ? (filt & ~filt_dly_q) : 1'b0;

  // A new event on the same edge as a clear keeps the flag set.
  assign evt_sts_d = sync_pulse_o | (evt_sts_q & ~evt_clr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_sts_q <= 1'b0;
    else        evt_sts_q <= evt_sts_d;
  end

  assign evt_sts_o = evt_sts_q;

endmodule

// File: rtl/csi2tx_multi_sync_filter.sv
// rtl/csi2tx_multi_sync_filter.sv - multi-channel async input synchroniser with filter and event status
module csi2tx_multi_sync_filter
  import csi2tx_multi_sync_filter_pkg::*;
#(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       STAGES     = 2,
  parameter int unsigned       FILTER_CNT = 0,
  parameter logic [NUM_CH-1:0] RST_VAL    = '0,
  parameter logic [NUM_CH-1:0] RISE_MASK  = '0,
  parameter logic [NUM_CH-1:0] TGL_MASK   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] sync_lvl,
  output logic [NUM_CH-1:0] sync_pulse,
  output logic              any_pulse,
  output logic [NUM_CH-1:0] evt_sts,
  input  logic [NUM_CH-1:0] evt_clr
);

  if (STAGES < CSI2TX_SYNC_MIN_STAGES || STAGES > CSI2TX_SYNC_MAX_STAGES) begin : g_bad_stages
    $error("csi2tx_multi_sync_filter: STAGES must be in 2..4");
  end
  if (FILTER_CNT > CSI2TX_SYNC_MAX_FILT) begin : g_bad_filt
    $error("csi2tx_multi_sync_filter: FILTER_CNT must be <= 255");
  end
  if (NUM_CH < 1 || NUM_CH > CSI2TX_SYNC_MAX_CH) begin : g_bad_ch
    $error("csi2tx_multi_sync_filter: NUM_CH must be in 1..32");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    csi2tx_sync_chan #(
      .STAGES    (STAGES),
      .FILTER_CNT(FILTER_CNT),
      .RST_VAL   (RST_VAL[i]),
      .RISE      (RISE_MASK[i]),
      .TGL       (TGL_MASK[i])
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .async_i     (async_in[i]),
      .evt_clr_i   (evt_clr[i]),
      .sync_lvl_o  (sync_lvl[i]),
      .sync_pulse_o(sync_pulse[i]),
      .evt_sts_o   (evt_sts[i])
    );
  end

  assign any_pulse = |sync_pulse;

endmodule

// File: tb/tb_csi2tx_multi_sync_filter.sv
// tb/tb_csi2tx_multi_sync_filter.sv - self-checking bench for csi2tx_multi_sync_filter
module tb_csi2tx_multi_sync_filter;

  localparam int          N    = 8;
  localparam int          S    = 3;
  localparam int          F    = 4;
  localparam logic [N-1:0] RSTV = 8'hF0;
  localparam logic [N-1:0] RISE = 8'h05;
  localparam logic [N-1:0] TGL  = 8'h46;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] async_in;
  logic [N-1:0] sync_lvl;
  logic [N-1:0] sync_pulse;
  logic         any_pulse;
  logic [N-1:0] evt_sts;
  logic [N-1:0] evt_clr;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] filt_m, filtd_m, sts_m;
  logic [N-1:0] hist[$];

  always #5 clk = ~clk;

  csi2tx_multi_sync_filter #(
    .NUM_CH(N), .STAGES(S), .FILTER_CNT(F),
    .RST_VAL(RSTV), .RISE_MASK(RISE), .TGL_MASK(TGL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .async_in(async_in),
    .sync_lvl(sync_lvl), .sync_pulse(sync_pulse), .any_pulse(any_pulse),
    .evt_sts(evt_sts), .evt_clr(evt_clr)
  );

  function automatic logic [N-1:0] mode_pulse(input logic [N-1:0] f, input logic [N-1:0] fd);
    return ((f ^ fd) & TGL) | (f & ~fd & RISE & ~TGL);
  endfunction

  task automatic model_reset();
    filt_m  = RSTV;
    filtd_m = RSTV;
    sts_m   = '0;
    hist.delete();
    for (int k = 0; k < S + F; k++) hist.push_back(RSTV);
  endtask

  // The filtered level takes the raw value once raw has shown it on the last F edges.
  task automatic model_edge();
    logic [N-1:0] p;
    bit agree;
    p       = mode_pulse(filt_m, filtd_m);
    sts_m   = p | (sts_m & ~evt_clr);
    filtd_m = filt_m;
    for (int c = 0; c < N; c++) begin
      agree = 1'b1;
      for (int j = 0; j < F; j++)
        if (hist[hist.size() - S - j][c] == filt_m[c]) agree = 1'b0;
      if (agree) filt_m[c] = ~filt_m[c];
    end
    hist.push_back(async_in);
    while (hist.size() > S + F) void'(hist.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; async_in = RSTV; evt_clr = '0;
    model_reset();
    repeat (2) step();
    checks++; if (sync_lvl !== RSTV) begin errors++; $display("FAIL reset_lvl got %h want %h", sync_lvl, RSTV); end
    checks++; if (sync_pulse !== '0) begin errors++; $display("FAIL reset_pulse got %h want 0", sync_pulse); end
    checks++; if (evt_sts !== '0) begin errors++; $display("FAIL reset_sts got %h want 0", evt_sts); end
    checks++; if (any_pulse !== 1'b0) begin errors++; $display("FAIL reset_any got %b want 0", any_pulse); end
    rst_n = 1'b1;
    repeat (10) begin
      step();
      checks++; if (sync_pulse !== '0 || sync_lvl !== RSTV) begin errors++; $display("FAIL post_reset got lvl %h pulse %h want %h 0", sync_lvl, sync_pulse, RSTV); end
    end
  endtask

  task automatic test_rise_filter();
    async_in[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++; if (sync_lvl[0] !== (k >= 6)) begin errors++; $display("FAIL rise_lvl k=%0d got %b want %b", k, sync_lvl[0], k >= 6); end
      checks++; if (sync_pulse[0] !== (k == 6)) begin errors++; $display("FAIL rise_pulse k=%0d got %b want %b", k, sync_pulse[0], k == 6); end
      checks++; if (evt_sts[0] !== (k >= 7)) begin errors++; $display("FAIL rise_sts k=%0d got %b want %b", k, evt_sts[0], k >= 7); end
      checks++; if (sync_lvl !== filt_m) begin errors++; $display("FAIL rise_model got %h want %h", sync_lvl, filt_m); end
    end
  endtask

  task automatic test_glitch();
    async_in[0] = 1'b0;
    repeat (12) step();
    checks++; if (sync_lvl[0] !== 1'b0) begin errors++; $display("FAIL glitch_pre got %b want 0", sync_lvl[0]); end
    async_in[0] = 1'b1;
    repeat (3) step();
    async_in[0] = 1'b0;
    repeat (12) begin
      step();
      checks++; if (sync_lvl[0] !== 1'b0 || sync_pulse[0] !== 1'b0) begin errors++; $display("FAIL glitch got lvl %b pulse %b want 0 0", sync_lvl[0], sync_pulse[0]); end
    end
  endtask

  task automatic test_toggle();
    int npulse;
    npulse = 0;
    for (int ph = 0; ph < 2; ph++) begin
      async_in[1] = (ph == 0);
      repeat (10) begin
        step();
        if (sync_pulse[1] === 1'b1) npulse++;
        checks++; if (any_pulse !== (|sync_pulse)) begin errors++; $display("FAIL toggle_any got %b want %b", any_pulse, |sync_pulse); end
        checks++; if (sync_pulse !== mode_pulse(filt_m, filtd_m)) begin errors++; $display("FAIL toggle_pulse got %h want %h", sync_pulse, mode_pulse(filt_m, filtd_m)); end
      end
    end
    checks++; if (npulse != 2) begin errors++; $display("FAIL toggle_count got %0d want 2", npulse); end
  endtask

  task automatic test_clear();
    int budget;
    budget = 0;
    async_in[0] = 1'b1;
    do begin step(); budget++; end while (sync_pulse[0] !== 1'b1 && budget < 20);
    checks++; if (sync_pulse[0] !== 1'b1) begin errors++; $display("FAIL clear_wait got pulse %b want 1 within 20 cycles", sync_pulse[0]); end
    evt_clr[0] = 1'b1;
    step();
    checks++; if (evt_sts[0] !== 1'b1) begin errors++; $display("FAIL clear_set_wins got %b want 1", evt_sts[0]); end
    step();
    checks++; if (evt_sts[0] !== 1'b0) begin errors++; $display("FAIL clear_idle got %b want 0", evt_sts[0]); end
    evt_clr[0] = 1'b0;
    step();
    checks++; if (evt_sts !== sts_m) begin errors++; $display("FAIL clear_model got %h want %h", evt_sts, sts_m); end
  endtask

  task automatic test_reset_midfilter();
    int p_all, p5, p6;
    async_in[4] = 1'b0;
    repeat (S + 2) step();
    #2 rst_n = 1'b0;
    #1 model_reset();
    checks++; if (sync_lvl !== RSTV || sync_pulse !== '0 || evt_sts !== '0 || any_pulse !== 1'b0) begin
      errors++; $display("FAIL midreset got lvl %h pulse %h sts %h any %b want %h 0 0 0", sync_lvl, sync_pulse, evt_sts, any_pulse, RSTV);
    end
    async_in = RSTV; evt_clr = '0;
    repeat (2) step();
    rst_n = 1'b1;
    p_all = 0;
    repeat (20) begin step(); if (sync_pulse !== '0) p_all++; end
    checks++; if (p_all != 0) begin errors++; $display("FAIL release_quiet got %0d pulses want 0", p_all); end
    checks++; if (sync_lvl !== RSTV) begin errors++; $display("FAIL release_lvl got %h want %h", sync_lvl, RSTV); end
    rst_n = 1'b0;
    #1 model_reset();
    async_in = RSTV & ~8'h60;
    step();
    rst_n = 1'b1;
    p_all = 0; p5 = 0; p6 = 0;
    repeat (20) begin
      step();
      if (sync_pulse[5] === 1'b1) p5++;
      if (sync_pulse[6] === 1'b1) p6++;
      if ((sync_pulse & ~8'h60) !== '0) p_all++;
    end
    checks++; if (p6 != 1) begin errors++; $display("FAIL release_tgl got %0d pulses want 1", p6); end
    checks++; if (p5 != 0 || p_all != 0) begin errors++; $display("FAIL release_other got %0d/%0d pulses want 0", p5, p_all); end
    checks++; if (sync_lvl !== filt_m) begin errors++; $display("FAIL release_model got %h want %h", sync_lvl, filt_m); end
  endtask

  task automatic test_random();
    logic [N-1:0] flip, clr;
    for (int t = 0; t < 500; t++) begin
      flip = '0; clr = '0;
      for (int c = 0; c < N; c++) begin
        flip[c] = ($urandom_range(0, 5) == 0);
        clr[c]  = ($urandom_range(0, 7) == 0);
      end
      async_in = async_in ^ flip;
      evt_clr  = clr;
      step();
      checks++; if ($isunknown({sync_lvl, sync_pulse, evt_sts, any_pulse})) begin errors++; $display("FAIL rand_x t=%0d got X on outputs", t); end
      checks++; if (sync_lvl !== filt_m) begin errors++; $display("FAIL rand_lvl t=%0d got %h want %h", t, sync_lvl, filt_m); end
      checks++; if (sync_pulse !== mode_pulse(filt_m, filtd_m)) begin errors++; $display("FAIL rand_pulse t=%0d got %h want %h", t, sync_pulse, mode_pulse(filt_m, filtd_m)); end
      checks++; if (evt_sts !== sts_m) begin errors++; $display("FAIL rand_sts t=%0d got %h want %h", t, evt_sts, sts_m); end
      checks++; if (any_pulse !== (|mode_pulse(filt_m, filtd_m))) begin errors++; $display("FAIL rand_any t=%0d got %b", t, any_pulse); end
    end
    evt_clr = '0;
  endtask

  initial begin
    test_reset();
    test_rise_filter();
    test_glitch();
    test_toggle();
    test_clear();
    test_reset_midfilter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
